// File: rtl/gate_tt_defs_pkg.sv
// Shared state encodings and truth-table row constants
// for the gate truth-table sequencer.
package gate_tt_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] ROW_00 = 2'b00;
    localparam logic [1:0] ROW_01 = 2'b01;
    localparam logic [1:0] ROW_10 = 2'b10;
    localparam logic [1:0] ROW_11 = 2'b11;

endpackage

// File: rtl/gate_tt_sequencer_dwell_counter.sv
// Dwell counter: counts cycles a row is held and flags the
// final cycle (count == DWELL-1).
module dwell_counter #(
    parameter int DWELL = 50,
    localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [W-1:0] LAST_CNT = W'(DWELL - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps a 2-input gate through rows 00..11, holding each row
// DWELL cycles and checking the gate output on the last one.
module gate_tt_sequencer
    import gate_tt_defs_pkg::*;
#(
    parameter int DWELL = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] exp_tt,
    input  logic       gate_o,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       last, cnt_clr, cnt_en;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        exp_d   = exp_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        gate_a  = 1'b0;
        gate_b  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = exp_tt;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                    row_d   = ROW_00;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                busy             = 1'b1;
                {gate_a, gate_b} = row_q;
                cnt_en           = 1'b1;
                cnt_clr          = last;
                if (last) begin
                    if (gate_o != exp_q[row_q])
                        fail_d[row_q] = 1'b1;
                    if (row_q == ROW_11) begin
                        // pass must already be valid in the done cycle
                        pass_d  = (fail_d == 4'b0000);
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                row_d   = ROW_00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                row_d   = ROW_00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            row_q   <= ROW_00;
            exp_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            exp_q   <= exp_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign pass      = pass_q;
    assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Self-checking bench for gate_tt_sequencer with DWELL=4.
module tb_gate_tt_sequencer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] exp_tt = 4'b0000;
    logic       gate_o;
    logic       gate_a, gate_b, busy, done, pass;
    logic [3:0] fail_mask;
    logic [3:0] lut_r = 4'b0111;

    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // gate under control: truth table indexed by {A,B}
    assign gate_o = lut_r[{gate_a, gate_b}];

    gate_tt_sequencer #(.DWELL(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .exp_tt    (exp_tt),
        .gate_o    (gate_o),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask)
    );

    typedef struct {
        logic [3:0] lut;
        logic [3:0] exp;
        logic [3:0] new_exp;
        int         chg_cyc;
        int         pmode;
        logic [3:0] want_fail;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep; cycle c is the period after edge c-1, edge 0 accepts start.
    // pmode: 0 no extra starts, 1 starts at cycles 6 and 17, 2 random starts.
    task automatic sweep(input logic [3:0] lut, input logic [3:0] e,
                         input logic [3:0] new_e, input int chg_cyc,
                         input int pmode, input logic [3:0] want_fail);
        logic [1:0] r;
        logic [3:0] ob;
        lut_r  = lut;
        exp_tt = e;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4 * D + 2; c++) begin
            if (c <= 4 * D) begin
                r  = 2'((c - 1) / D);
                ob = {r, 2'b10};
            end else if (c == 4 * D + 1) begin
                ob = 4'b0011;
            end else begin
                ob = 4'b0000;
            end
            chk("ab_busy_done", {4'h0, gate_a, gate_b, busy, done},
                {4'h0, ob});
            if (c >= 4 * D + 1) begin
                chk("pass", {7'h0, pass}, {7'h0, (want_fail == 4'b0)});
                chk("fail_mask", {4'h0, fail_mask}, {4'h0, want_fail});
            end
            case (pmode)
                1: start = (c == 6) || (c == 4 * D + 1);
                2: start = (c <= 4 * D + 1) && ($urandom_range(0, 3) == 0);
                default: start = 1'b0;
            endcase
            if (c == chg_cyc)
                exp_tt = new_e;
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] lut, e, ne;
        tbl[0] = '{4'b0111, 4'b0111, 4'b0111, 0, 0, 4'b0000};
        tbl[1] = '{4'b1111, 4'b0111, 4'b0111, 0, 0, 4'b1000};
        tbl[2] = '{4'b0000, 4'b0111, 4'b0111, 0, 0, 4'b0111};
        tbl[3] = '{4'b0111, 4'b0111, 4'b0111, 0, 1, 4'b0000};
        tbl[4] = '{4'b0111, 4'b0111, 4'b1111, 3, 0, 4'b0000};
        tbl[5] = '{4'b0110, 4'b0111, 4'b0000, 9, 1, 4'b0001};

        #2;
        chk("reset_outs", {1'b0, gate_a, gate_b, busy, done, pass, 2'b0},
            8'h00);
        chk("reset_mask", {4'h0, fail_mask}, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            sweep(tbl[i].lut, tbl[i].exp, tbl[i].new_exp, tbl[i].chg_cyc,
                  tbl[i].pmode, tbl[i].want_fail);

        // idle hold of last result
        repeat (3) tick();
        chk("hold_pass", {7'h0, pass}, 8'h00);
        chk("hold_mask", {4'h0, fail_mask}, 8'h01);

        // reset mid-sweep at cycle 10, restart at cycle 20
        lut_r  = 4'b0111;
        exp_tt = 4'b0111;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        chk("pre_reset_row", {5'h0, gate_a, gate_b, busy}, 8'h05);
        reset_n = 1'b0;
        #1;
        chk("async_reset", {1'b0, gate_a, gate_b, busy, done, pass, 2'b0},
            8'h00);
        for (int c = 10; c < 20; c++) begin
            if (c == 12)
                reset_n = 1'b1;
            chk("no_done_after_rst", {6'h0, busy, done}, 8'h00);
            tick();
        end
        sweep(4'b0111, 4'b0111, 4'b0111, 0, 0, 4'b0000);

        // randomized sweeps against the truth-table model
        for (int n = 0; n < 20; n++) begin
            lut = 4'($urandom);
            e   = 4'($urandom);
            ne  = 4'($urandom);
            sweep(lut, e, ne, int'($urandom_range(1, 4 * D)), 2, lut ^ e);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
